// File: rtl/matrix_scan_driver_pkg.sv
// Shared types and helpers for the row-scan LED matrix driver.
// Holds the slot-phase enum and the output polarity helper.
package matrix_pkg;

  typedef enum logic {
    PH_BLANK,
    PH_ACTIVE
  } phase_e;

  // Widest row/column vector the polarity helper handles.
  localparam int POL_W = 64;

  function automatic logic [POL_W-1:0] apply_pol(
    input logic             active_low,
    input logic [POL_W-1:0] raw
  );
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Bus between game logic (master) and the matrix scan driver (slave).
// Carries row writes, swap control, brightness, status and pin drives.
interface matrix_scan_driver_if #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int BRIGHT_W = 3
) ();

  logic                    wr_en;
  logic [$clog2(ROWS)-1:0] wr_row;
  logic [COLS-1:0]         wr_data;
  logic                    swap_req;
  logic [BRIGHT_W-1:0]     brightness;
  logic                    swap_pending;
  logic                    swap_done;
  logic                    frame_start;
  logic [ROWS-1:0]         row_out;
  logic [COLS-1:0]         col_out;

  modport master (
    output wr_en, wr_row, wr_data,
    output swap_req, brightness,
    input  swap_pending, swap_done,
    input  frame_start, row_out, col_out
  );

  modport slave (
    input  wr_en, wr_row, wr_data,
    input  swap_req, brightness,
    output swap_pending, swap_done,
    output frame_start, row_out, col_out
  );

endinterface

// File: rtl/matrix_scan_driver_slot_timer.sv
// Slot/row scan timer: slot counter, row index, phase and strobes.
// Ports: clk, rst in; row_idx, phase, slot/frame first/last strobes out.
module matrix_slot_timer
  import matrix_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int ROW_CYCLES   = 27000,
  parameter int BLANK_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output phase_e                  phase,
  output logic                    slot_start,
  output logic                    slot_last,
  output logic                    frame_first,
  output logic                    frame_last
);

  localparam int SW = $clog2(ROW_CYCLES);
  localparam int RW = $clog2(ROWS);

  localparam logic [SW-1:0] SLOT_MAX = SW'(ROW_CYCLES - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);

  logic [SW-1:0] slot_q;
  logic [RW-1:0] row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      row_q  <= '0;
    end else if (slot_last) begin
      slot_q <= '0;
      if (row_q == ROW_MAX)
        row_q <= '0;
      else
        row_q <= row_q + 1'b1;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  assign row_idx     = row_q;
  assign slot_start  = (slot_q == '0);
  assign slot_last   = (slot_q == SLOT_MAX);
  assign frame_first = slot_start && (row_q == '0);
  assign frame_last  = slot_last && (row_q == ROW_MAX);

  always_comb begin
    phase = PH_ACTIVE;
    if (int'(slot_q) < BLANK_CYCLES)
      phase = PH_BLANK;
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-scan LED matrix driver: double-buffered frame store, PWM, swaps.
// Ports: clk, rst; bus (slave) with writes, swap, brightness, pin drives.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int ROW_CYCLES     = 27000,
  parameter int BLANK_CYCLES   = 32,
  parameter int BRIGHT_W       = 3,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  matrix_scan_driver_if.slave  bus
);

  localparam int RW = $clog2(ROWS);

  localparam logic [ROWS-1:0] ROW_IDLE =
    {ROWS{ROW_ACTIVE_LOW}};
  localparam logic [COLS-1:0] COL_IDLE =
    {COLS{COL_ACTIVE_LOW}};

  logic [RW-1:0] row_idx;
  phase_e        phase;
  logic          slot_start;
  logic          slot_last;
  logic          frame_first;
  logic          frame_last;

  matrix_slot_timer #(
    .ROWS         (ROWS),
    .ROW_CYCLES   (ROW_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .row_idx     (row_idx),
    .phase       (phase),
    .slot_start  (slot_start),
    .slot_last   (slot_last),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  logic [COLS-1:0]     buf_q [2][ROWS];
  logic                front_q;
  logic                pend_q;
  logic [COLS-1:0]     row_latch_q;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [ROWS-1:0]     row_out_q;
  logic [COLS-1:0]     col_out_q;
  logic                frame_start_q;

  logic                take_swap;
  logic                wr_ok;
  logic [COLS-1:0]     disp_row;
  logic                duty_on;
  logic [ROWS-1:0]     row_raw;
  logic [COLS-1:0]     col_raw;
  logic [POL_W-1:0]    row_pol;
  logic [POL_W-1:0]    col_pol;
  logic [ROWS-1:0]     row_d;
  logic [COLS-1:0]     col_d;

  // A request arriving in the swap cycle itself joins that swap.
  assign take_swap = frame_last && (pend_q || bus.swap_req);
  assign wr_ok     = bus.wr_en && (int'(bus.wr_row) < ROWS);

  // At slot start the latch is still being loaded; bypass it.
  assign disp_row = slot_start ? buf_q[front_q][row_idx]
                               : row_latch_q;

  assign duty_on = (bus.brightness == '1) ||
                   (pwm_q < bus.brightness);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          buf_q[b][r] <= '0;
    end else if (wr_ok) begin
      // Back buffer is selected with the pre-swap front.
      buf_q[~front_q][bus.wr_row] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
    end else if (take_swap) begin
      front_q <= ~front_q;
      pend_q  <= 1'b0;
    end else if (bus.swap_req) begin
      pend_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      row_latch_q <= '0;
    else if (slot_start)
      row_latch_q <= buf_q[front_q][row_idx];
  end

  // PWM phase restarts each slot so every row sees the same duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pwm_q <= '0;
    else if (slot_last || phase == PH_BLANK)
      pwm_q <= '0;
    else
      pwm_q <= pwm_q + 1'b1;
  end

  always_comb begin
    row_raw = '0;
    col_raw = '0;
    if (phase == PH_ACTIVE) begin
      row_raw[row_idx] = 1'b1;
      if (duty_on)
        col_raw = disp_row;
    end
  end

  always_comb begin
    row_pol = apply_pol(ROW_ACTIVE_LOW, POL_W'(row_raw));
    col_pol = apply_pol(COL_ACTIVE_LOW, POL_W'(col_raw));
    row_d   = row_pol[ROWS-1:0];
    col_d   = col_pol[COLS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_out_q     <= ROW_IDLE;
      col_out_q     <= COL_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      row_out_q     <= row_d;
      col_out_q     <= col_d;
      frame_start_q <= frame_first;
    end
  end

  assign bus.row_out      = row_out_q;
  assign bus.col_out      = col_out_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.swap_pending = pend_q;
  assign bus.swap_done    = take_swap;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver (4x4, 8-cycle slots, 2 blank).
// cyc counts posedges since reset release; outputs lag counters by 1.
module tb_matrix_scan_driver;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int RC   = 8;
  localparam int BC   = 2;
  localparam int BW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  matrix_scan_driver_if #(
    .ROWS(ROWS), .COLS(COLS), .BRIGHT_W(BW)
  ) bus ();

  matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS),
    .ROW_CYCLES(RC), .BLANK_CYCLES(BC),
    .BRIGHT_W(BW),
    .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic idle_inputs();
    bus.wr_en      = 1'b0;
    bus.wr_row     = '0;
    bus.wr_data    = '0;
    bus.swap_req   = 1'b0;
    bus.brightness = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic write_row(input int r, input logic [3:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_row  = 2'(r);
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int bad;
    do_reset();
    checks++;
    if (bus.row_out !== 4'hF) begin
      errors++;
      $display("FAIL rst_row got=%h want=f", bus.row_out);
    end
    checks++;
    if (bus.col_out !== 4'h0) begin
      errors++;
      $display("FAIL rst_col got=%h want=0", bus.col_out);
    end
    checks++;
    if ({bus.frame_start, bus.swap_pending, bus.swap_done}
        !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags got=%b%b%b want=000",
               bus.frame_start, bus.swap_pending, bus.swap_done);
    end
    tick();
    checks++;
    if (bus.frame_start !== 1'b1 || bus.row_out !== 4'hF) begin
      errors++;
      $display("FAIL first_fs got fs=%b row=%h want fs=1 row=f",
               bus.frame_start, bus.row_out);
    end
    run_to(3);
    checks++;
    if (bus.row_out !== 4'hE || bus.col_out !== 4'h0) begin
      errors++;
      $display("FAIL row0_active got row=%h col=%h want e 0",
               bus.row_out, bus.col_out);
    end
    n = 0;
    bad = 0;
    while (cyc < 70) begin
      tick();
      if (bus.frame_start === 1'b1) begin
        n++;
        if (cyc % 32 != 1) bad++;
      end
    end
    checks++;
    if (n != 2 || bad != 0) begin
      errors++;
      $display("FAIL fs_period got n=%0d bad=%0d want 2 0", n, bad);
    end
  endtask

  task automatic test_write_swap();
    int n;
    do_reset();
    bus.brightness = 2'd3;
    write_row(0, 4'h1);
    write_row(1, 4'h2);
    write_row(2, 4'h4);
    checks++;
    if (bus.col_out !== 4'h0) begin
      errors++;
      $display("FAIL back_hidden got=%h want=0", bus.col_out);
    end
    write_row(3, 4'h8);
    run_to(5);
    pulse_swap();
    checks++;
    if (bus.swap_pending !== 1'b1) begin
      errors++;
      $display("FAIL pend_set got=%b want=1", bus.swap_pending);
    end
    run_to(30);
    checks++;
    if (bus.swap_pending !== 1'b1 || bus.swap_done !== 1'b0) begin
      errors++;
      $display("FAIL pend_hold got p=%b d=%b want 1 0",
               bus.swap_pending, bus.swap_done);
    end
    tick();
    checks++;
    if (bus.swap_done !== 1'b1) begin
      errors++;
      $display("FAIL swap_done31 got=%b want=1", bus.swap_done);
    end
    tick();
    checks++;
    if (bus.swap_pending !== 1'b0 || bus.swap_done !== 1'b0) begin
      errors++;
      $display("FAIL swap_clr got p=%b d=%b want 0 0",
               bus.swap_pending, bus.swap_done);
    end
    run_to(35);
    checks++;
    if (bus.row_out !== 4'hE || bus.col_out !== 4'h1) begin
      errors++;
      $display("FAIL new_row0 got row=%h col=%h want e 1",
               bus.row_out, bus.col_out);
    end
    run_to(50);
    checks++;
    if (bus.row_out !== 4'hF || bus.col_out !== 4'h0) begin
      errors++;
      $display("FAIL blank_row2 got row=%h col=%h want f 0",
               bus.row_out, bus.col_out);
    end
    n = 0;
    while (cyc < 56) begin
      tick();
      if (bus.row_out === 4'hB && bus.col_out === 4'h4) n++;
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL row2_slot got=%0d want=6 cycles", n);
    end
    tick();
    checks++;
    if (bus.row_out !== 4'hF) begin
      errors++;
      $display("FAIL row3_blank got=%h want=f", bus.row_out);
    end
  endtask

  task automatic test_brightness();
    int n;
    logic [5:0] mask;
    do_reset();
    bus.brightness = 2'd0;
    write_row(0, 4'hF);
    write_row(1, 4'hF);
    write_row(2, 4'hF);
    write_row(3, 4'hF);
    pulse_swap();
    run_to(34);
    n = 0;
    while (cyc < 40) begin
      tick();
      if (bus.col_out === 4'hF) n++;
    end
    checks++;
    if (n != 0 || bus.row_out !== 4'hE) begin
      errors++;
      $display("FAIL bright0 got n=%0d row=%h want 0 e",
               n, bus.row_out);
    end
    run_to(41);
    bus.brightness = 2'd1;
    run_to(42);
    mask = '0;
    while (cyc < 48) begin
      tick();
      if (bus.col_out === 4'hF) mask[cyc-43] = 1'b1;
    end
    checks++;
    if (mask !== 6'b010001) begin
      errors++;
      $display("FAIL bright1 got=%b want=010001", mask);
    end
    run_to(49);
    bus.brightness = 2'd3;
    run_to(50);
    n = 0;
    while (cyc < 56) begin
      tick();
      if (bus.col_out === 4'hF) n++;
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL bright3 got=%0d want=6", n);
    end
  endtask

  task automatic test_no_tear();
    int n;
    int at;
    do_reset();
    bus.brightness = 2'd3;
    write_row(1, 4'h3);
    pulse_swap();
    run_to(42);
    write_row(1, 4'hC);
    n = (bus.col_out === 4'h3) ? 1 : 0;
    while (cyc < 48) begin
      tick();
      if (bus.col_out === 4'h3) n++;
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL no_tear got=%0d want=6", n);
    end
    run_to(50);
    pulse_swap();
    run_to(55);
    pulse_swap();
    n = 0;
    at = -1;
    while (cyc < 95) begin
      tick();
      if (bus.swap_done === 1'b1) begin
        n++;
        at = cyc;
      end
    end
    checks++;
    if (n != 1 || at != 63) begin
      errors++;
      $display("FAIL one_swap got n=%0d at=%0d want 1 63", n, at);
    end
    run_to(108);
    checks++;
    if (bus.row_out !== 4'hD || bus.col_out !== 4'hC) begin
      errors++;
      $display("FAIL swapped_row1 got row=%h col=%h want d c",
               bus.row_out, bus.col_out);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    bus.brightness = 2'd3;
    run_to(31);
    bus.swap_req = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_row   = 2'd0;
    bus.wr_data  = 4'hA;
    #1;
    checks++;
    if (bus.swap_done !== 1'b1) begin
      errors++;
      $display("FAIL edge_done got=%b want=1", bus.swap_done);
    end
    tick();
    bus.swap_req = 1'b0;
    bus.wr_en    = 1'b0;
    checks++;
    if (bus.swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL edge_pend got=%b want=0", bus.swap_pending);
    end
    run_to(36);
    checks++;
    if (bus.row_out !== 4'hE || bus.col_out !== 4'hA) begin
      errors++;
      $display("FAIL edge_row0 got row=%h col=%h want e a",
               bus.row_out, bus.col_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.brightness = 2'd3;
    write_row(2, 4'h5);
    pulse_swap();
    run_to(53);
    checks++;
    if (bus.row_out !== 4'hB || bus.col_out !== 4'h5) begin
      errors++;
      $display("FAIL pre_rst got row=%h col=%h want b 5",
               bus.row_out, bus.col_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.row_out !== 4'hF || bus.col_out !== 4'h0) begin
      errors++;
      $display("FAIL async_rst got row=%h col=%h want f 0",
               bus.row_out, bus.col_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    tick();
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart got=%b want=1", bus.frame_start);
    end
    run_to(3);
    checks++;
    if (bus.row_out !== 4'hE) begin
      errors++;
      $display("FAIL rst_row0 got=%h want=e", bus.row_out);
    end
    run_to(4);
    pulse_swap();
    run_to(53);
    checks++;
    if (bus.row_out !== 4'hB || bus.col_out !== 4'h0) begin
      errors++;
      $display("FAIL buf_clr got row=%h col=%h want b 0",
               bus.row_out, bus.col_out);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_swap();
    test_brightness();
    test_no_tear();
    test_boundary();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
